// File: rtl/pipelined_cla_adder_if.sv
// Operand/result stream bundle for the pipelined CLA adder; master drives
// operands and result acceptance, slave (the adder) drives ready and results.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Two-stage add/sub with two-level carry lookahead: 2-cycle latency, one beat/cycle;
// valid/ready skid-free pipeline, a stalled output holds and in_ready drops only when both stages are full.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_cla_adder_if.slave bus
);

  localparam int NGROUPS = WIDTH / GROUP;

  generate
    if (WIDTH < 4 || WIDTH > 64 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("pipelined_cla_adder: WIDTH must be a multiple of 4 in 4..64");
    end
    if (GROUP != 4) begin : g_bad_group
      $error("pipelined_cla_adder: GROUP must be 4");
    end
  endgenerate

  // Flat sum-of-products carry out of the low n positions:
  // G[n-1] | P[n-1]G[n-2] | ... | P[n-1..0]c_in, no position-to-position ripple.
  function automatic logic cla_carry(input logic [15:0] gv, input logic [15:0] pv,
                                     input logic c_in, input int n);
    logic res;
    logic term;
    res = c_in;
    for (int j = 0; j < 16; j++) begin
      if (j < n) res = res & pv[j];
    end
    for (int j = 0; j < 16; j++) begin
      if (j < n) begin
        term = gv[j];
        for (int m = 0; m < 16; m++) begin
          if (m > j && m < n) term = term & pv[m];
        end
        res = res | term;
      end
    end
    return res;
  endfunction

  logic adv2;
  logic v1;
  logic v2;

  // ---------------- stage 1: bit and group generate/propagate ----------------
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   p_in;
  logic [WIDTH-1:0]   g_in;
  logic               c0_in;
  logic [NGROUPS-1:0] grp_g_in;
  logic [NGROUPS-1:0] grp_p_in;

  always_comb begin
    b_eff    = bus.op_sub ? ~bus.b : bus.b;
    p_in     = bus.a ^ b_eff;
    g_in     = bus.a & b_eff;
    // Subtract is a + ~b + 1, so the caller's cin is ignored there.
    c0_in    = bus.op_sub ? 1'b1 : bus.cin;
    grp_g_in = '0;
    grp_p_in = '0;
    for (int k = 0; k < NGROUPS; k++) begin
      grp_g_in[k] = cla_carry(16'(g_in[k*GROUP +: GROUP]), 16'(p_in[k*GROUP +: GROUP]),
                              1'b0, GROUP);
      grp_p_in[k] = &p_in[k*GROUP +: GROUP];
    end
  end

  logic [WIDTH-1:0]   p_r;
  logic [WIDTH-1:0]   g_r;
  logic               c0_r;
  logic [NGROUPS-1:0] grp_g_r;
  logic [NGROUPS-1:0] grp_p_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      p_r     <= '0;
      g_r     <= '0;
      c0_r    <= 1'b0;
      grp_g_r <= '0;
      grp_p_r <= '0;
    end else if (bus.in_ready) begin
      v1      <= bus.in_valid;
      p_r     <= p_in;
      g_r     <= g_in;
      c0_r    <= c0_in;
      grp_g_r <= grp_g_in;
      grp_p_r <= grp_p_in;
    end
  end

  // ---------------- stage 2: group carries, bit carries, flags ----------------
  logic [NGROUPS:0] grp_c;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_nx;
  logic             cout_nx;
  logic             ovf_nx;
  logic             zero_nx;

  always_comb begin
    grp_c = '0;
    carry = '0;
    for (int k = 0; k <= NGROUPS; k++) begin
      grp_c[k] = cla_carry(16'(grp_g_r), 16'(grp_p_r), c0_r, k);
    end
    for (int k = 0; k < NGROUPS; k++) begin
      for (int i = 0; i < GROUP; i++) begin
        carry[k*GROUP + i] = cla_carry(16'(g_r[k*GROUP +: GROUP]),
                                       16'(p_r[k*GROUP +: GROUP]), grp_c[k], i);
      end
    end
    carry[WIDTH] = grp_c[NGROUPS];
    sum_nx  = p_r ^ carry[WIDTH-1:0];
    cout_nx = carry[WIDTH];
    ovf_nx  = carry[WIDTH-1] ^ carry[WIDTH];
    zero_nx = (sum_nx == '0);
  end

  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else if (adv2) begin
      v2     <= v1;
      sum_r  <= sum_nx;
      cout_r <= cout_nx;
      ovf_r  <= ovf_nx;
      zero_r <= zero_nx;
    end
  end

  // ---------------- handshake ----------------
  assign adv2          = !v2 || bus.out_ready;
  assign bus.in_ready  = !v1 || adv2;
  assign bus.out_valid = v2;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
  assign bus.zero      = zero_r;

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a multiple of 4 in range 4..64, other values rejected at elaboration.
REQ-002 Parameter GROUP, fixed 4: bits per lookahead group; NGROUPS = WIDTH/GROUP.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, used in add mode only.
REQ-010 op_sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out of MSB (add: carry; sub: 1 = no borrow).
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  sum == 0.

Function
REQ-017 Add: {cout,sum} = a + b + cin; sub: {cout,sum} = a + ~b + 1, cin ignored.
REQ-018 ovf SHALL equal carry into MSB XOR cout.
REQ-019 Bit level: p = a ^ b', g = a & b', where b' = op_sub ? ~b : b.
REQ-020 Stage 1 SHALL register p, g, effective carry-in, and per-group gout/pout computed by 4-bit lookahead equations.
REQ-021 Stage 2 SHALL compute group carries by second-level lookahead over registered gout/pout (no group-to-group ripple), then intra-group carries, sum = p ^ carry, and register sum/cout/ovf/zero.
REQ-022 Beat accepted when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-023 Stage valids v1, v2; out_valid = v2; adv2 = !v2 | out_ready; in_ready = !v1 | adv2.
REQ-024 When adv2, stage 2 loads stage 1 contents and v2 <= v1; else stage 2 holds.
REQ-025 When in_ready, stage 1 loads input and v1 <= in_valid; else stage 1 holds.
REQ-026 Latency SHALL be exactly 2 cycles from acceptance to out_valid with no backpressure; throughput one beat/cycle.
REQ-027 While out_valid && !out_ready, sum/cout/ovf/zero SHALL remain stable.
REQ-028 Full (v1 && v2 && !out_ready) SHALL drive in_ready low; simultaneous accept and output transfer in one cycle SHALL lose and duplicate no beat.
REQ-029 Beats SHALL emerge in acceptance order; no internal reordering or dropping.
REQ-030 in_ready SHALL depend combinationally only on v1, v2, out_ready, never on in_valid.

Reset
REQ-031 rst_n low SHALL immediately clear v1, v2; out_valid = 0, in_ready = 1 during reset.
REQ-032 sum, cout, ovf, zero SHALL reset to 0.
REQ-033 Reset mid-operation SHALL discard all in-flight beats; first accepted beat after release obeys REQ-026.
REQ-034 Deassertion SHALL be synchronised externally; block assumes clean release.

Verification
REQ-035 WIDTH=16 add a=0xFFFF b=0x0001 cin=0, out_ready=1 -> 2 cycles later sum=0x0000 cout=1 zero=1 ovf=0.
REQ-036 WIDTH=16 add a=0x7FFF b=0x0001 cin=0 -> sum=0x8000 cout=0 ovf=1 zero=0; sub a=0x8000 b=0x0001 -> sum=0x7FFF cout=1 ovf=1.
REQ-037 Stream 8 back-to-back beats, out_ready=1 -> in_ready stays 1, 8 results in order on consecutive cycles.
REQ-038 out_ready=0 while 3 beats offered -> 2 accepted, in_ready=0, outputs stable; out_ready=1 -> both drain in order, third accepted on the same cycle.
REQ-039 Assert rst_n low with v1=v2=1 -> out_valid=0 immediately; after release, no stale beat appears.
REQ-040 WIDTH=4, 32 and 64: random add/sub vs reference model, 10k beats, random backpressure -> zero mismatches.
